// File: rtl/lap_timer_core_if.sv
// Signal bundle between the stopwatch core and its controller/readout logic.
// Lap read handshake: an entry is popped on a rising clk edge where rd_en && lap_valid; rd_en with lap_valid low is ignored.
interface lap_timer_core_if #(
    parameter int TW = 20,
    parameter int AW = 3
);
    logic          tick;
    logic          strtstop;
    logic          lap;
    logic          load;
    logic          up;
    logic [TW-1:0] preset;
    logic          rd_en;
    logic [TW-1:0] time_out;
    logic          running;
    logic          expired;
    logic [TW-1:0] lap_data;
    logic          lap_valid;
    logic          lap_full;
    logic [AW:0]   lap_count;
    logic          lap_ovf;
    logic [1:0]    state_dbg;

    modport master (
        output tick, strtstop, lap, load, up, preset, rd_en,
        input  time_out, running, expired, lap_data, lap_valid, lap_full, lap_count, lap_ovf, state_dbg
    );

    modport slave (
        input  tick, strtstop, lap, load, up, preset, rd_en,
        output time_out, running, expired, lap_data, lap_valid, lap_full, lap_count, lap_ovf, state_dbg
    );
endinterface

// File: rtl/lap_timer_core.sv
// BCD stopwatch/countdown timer with a show-ahead lap FIFO; every output is a register.
module lap_timer_core #(
    parameter int MIN_DIGITS = 1,
    parameter int LAP_DEPTH  = 8
) (
    input  logic             clk,
    input  logic             reset,
    lap_timer_core_if.slave  bus
);
    localparam int TW = 16 + 4 * MIN_DIGITS;
    localparam int AW = $clog2(LAP_DEPTH);
    localparam int ND = 4 + MIN_DIGITS;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(LAP_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t        state;
    logic [TW-1:0] time_r;
    logic          running_r;
    logic          expired_r;

    // Digit 3 is the tens-of-seconds digit (0-5); all others are 0-9.
    // Out-of-range digits are forced to 0 and absorb any carry/borrow.
    function automatic logic [TW-1:0] bcd_step(input logic [TW-1:0] t, input logic inc);
        logic [TW-1:0] r;
        logic [3:0]    d;
        logic [3:0]    lim;
        logic          c;
        r = t;
        c = 1'b1;
        for (int i = 0; i < ND; i++) begin
            d   = t[4*i +: 4];
            lim = (i == 3) ? 4'd5 : 4'd9;
            if (d > lim) begin
                r[4*i +: 4] = 4'd0;
                c = 1'b0;
            end else if (c) begin
                if (inc) begin
                    if (d == lim) r[4*i +: 4] = 4'd0;
                    else begin
                        r[4*i +: 4] = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) r[4*i +: 4] = lim;
                    else begin
                        r[4*i +: 4] = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    logic [TW-1:0] dec_val;
    assign dec_val = bcd_step(time_r, 1'b0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            time_r    <= '0;
            running_r <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            expired_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) time_r <= bus.preset;
                    if (bus.strtstop) begin
                        state     <= RUN;
                        running_r <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.strtstop) begin
                        state     <= IDLE;
                        running_r <= 1'b0;
                    end else if (bus.tick) begin
                        if (bus.up) begin
                            time_r <= bcd_step(time_r, 1'b1);
                        end else if (time_r == '0 || dec_val == '0) begin
                            time_r    <= '0;
                            expired_r <= 1'b1;
                            state     <= DONE;
                            running_r <= 1'b0;
                        end else begin
                            time_r <= dec_val;
                        end
                    end
                end
                DONE: begin
                    if (bus.load) begin
                        time_r <= bus.preset;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    running_r <= 1'b0;
                end
            endcase
        end
    end

    logic [TW-1:0] mem [LAP_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [AW:0]   count, count_next;
    logic          push_ok, pop_ok;
    logic [TW-1:0] head_next;
    logic [TW-1:0] lap_data_r;
    logic          lap_valid_r, lap_full_r, lap_ovf_r;

    // A full FIFO still accepts a push when the same cycle pops, freeing a slot.
    always_comb begin
        pop_ok  = bus.rd_en && (count != '0);
        push_ok = bus.lap && ((count != DEPTH_C) || pop_ok);
        rd_next = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + (AW + 1)'(1);
            2'b01:   count_next = count - (AW + 1)'(1);
            default: count_next = count;
        endcase
        if (count_next == '0) head_next = '0;
        else if (push_ok && rd_next == wr_ptr) head_next = time_r;
        else head_next = mem[rd_next];
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem[wr_ptr] <= time_r;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            lap_data_r  <= '0;
            lap_valid_r <= 1'b0;
            lap_full_r  <= 1'b0;
            lap_ovf_r   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr      <= rd_next;
            count       <= count_next;
            lap_data_r  <= head_next;
            lap_valid_r <= (count_next != '0);
            lap_full_r  <= (count_next == DEPTH_C);
            if (bus.lap && !push_ok) lap_ovf_r <= 1'b1;
        end
    end

    assign bus.time_out  = time_r;
    assign bus.running   = running_r;
    assign bus.expired   = expired_r;
    assign bus.lap_data  = lap_data_r;
    assign bus.lap_valid = lap_valid_r;
    assign bus.lap_full  = lap_full_r;
    assign bus.lap_count = count;
    assign bus.lap_ovf   = lap_ovf_r;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_lap_timer_core.sv
// Directed bench for lap_timer_core (MIN_DIGITS=1, LAP_DEPTH=8); lap reads are scored from an expected queue.
module tb_lap_timer_core;
  localparam int TW = 20;
  localparam int AW = 3;

  logic clk;
  logic reset;
  int n_checks = 0;
  int n_pass = 0;
  int m_cnt = 0;
  logic [TW-1:0] exp_q[$];

  lap_timer_core_if #(.TW(TW), .AW(AW)) bus ();

  lap_timer_core #(.MIN_DIGITS(1), .LAP_DEPTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
    bus.strtstop = 1'b0;
    bus.lap = 1'b0;
    bus.load = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic do_load(input logic [TW-1:0] v);
    bus.preset = v;
    bus.load = 1'b1;
    step();
  endtask

  task automatic check_reset_vals();
    check("rst_time", 32'(bus.time_out), 32'h0);
    check("rst_running", 32'(bus.running), 32'h0);
    check("rst_expired", 32'(bus.expired), 32'h0);
    check("rst_state", 32'(bus.state_dbg), 32'h0);
    check("rst_lap_valid", 32'(bus.lap_valid), 32'h0);
    check("rst_lap_full", 32'(bus.lap_full), 32'h0);
    check("rst_lap_count", 32'(bus.lap_count), 32'h0);
    check("rst_lap_data", 32'(bus.lap_data), 32'h0);
    check("rst_lap_ovf", 32'(bus.lap_ovf), 32'h0);
  endtask

  // scoreboard monitor: a pop happens on the coming edge
  always @(negedge clk) begin
    if (!reset && bus.rd_en && bus.lap_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL lap_pop: got %h expected no entry", bus.lap_data);
      end else begin
        check("lap_data_pop", 32'(bus.lap_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    bus.tick = 1'b0;
    bus.strtstop = 1'b0;
    bus.lap = 1'b0;
    bus.load = 1'b0;
    bus.up = 1'b1;
    bus.preset = '0;
    bus.rd_en = 1'b0;
    reset = 1'b1;
    #1;
    step();
    step();
    check_reset_vals();
    reset = 1'b0;

    // count up across carries
    do_load(20'h00098);
    check("load_time", 32'(bus.time_out), 32'h00098);
    check("idle_running", 32'(bus.running), 32'h0);
    bus.strtstop = 1'b1; step();
    check("start_running", 32'(bus.running), 32'h1);
    bus.up = 1'b1;
    bus.tick = 1'b1; step();
    check("up_1", 32'(bus.time_out), 32'h00099);
    bus.tick = 1'b1; step();
    check("up_2", 32'(bus.time_out), 32'h00100);
    bus.tick = 1'b1; step();
    check("up_3", 32'(bus.time_out), 32'h00101);
    check("up_running", 32'(bus.running), 32'h1);

    // wrap at maximum; load+strtstop in IDLE
    bus.strtstop = 1'b1; step();
    check("stop_running", 32'(bus.running), 32'h0);
    bus.strtstop = 1'b1; do_load(20'h95999);
    check("idle_ld_ss_time", 32'(bus.time_out), 32'h95999);
    check("idle_ld_ss_run", 32'(bus.running), 32'h1);
    bus.tick = 1'b1; step();
    check("wrap_time", 32'(bus.time_out), 32'h00000);
    check("wrap_expired", 32'(bus.expired), 32'h0);
    check("wrap_running", 32'(bus.running), 32'h1);

    // load+strtstop in RUN: load ignored
    bus.strtstop = 1'b1; do_load(20'h33333);
    check("run_ld_ss_time", 32'(bus.time_out), 32'h00000);
    check("run_ld_ss_run", 32'(bus.running), 32'h0);

    // countdown to expiry
    do_load(20'h00002);
    bus.strtstop = 1'b1; step();
    bus.up = 1'b0;
    bus.tick = 1'b1; step();
    check("dn_1", 32'(bus.time_out), 32'h00001);
    check("dn_1_expired", 32'(bus.expired), 32'h0);
    bus.tick = 1'b1; step();
    check("dn_0", 32'(bus.time_out), 32'h00000);
    check("dn_0_expired", 32'(bus.expired), 32'h1);
    check("dn_0_running", 32'(bus.running), 32'h0);
    check("dn_0_state", 32'(bus.state_dbg), 32'h2);
    bus.tick = 1'b1; step();
    check("done_tick_time", 32'(bus.time_out), 32'h00000);
    check("done_expired_low", 32'(bus.expired), 32'h0);
    bus.strtstop = 1'b1; step();
    check("done_ss_state", 32'(bus.state_dbg), 32'h2);
    check("done_ss_running", 32'(bus.running), 32'h0);
    do_load(20'h00002);
    check("done_load_time", 32'(bus.time_out), 32'h00002);
    check("done_load_state", 32'(bus.state_dbg), 32'h0);

    // fill FIFO past capacity
    for (int i = 0; i < 9; i++) begin
      logic [TW-1:0] v;
      v = 20'h00105 | TW'(i << 4);
      do_load(v);
      bus.lap = 1'b1;
      if (m_cnt < 8) begin
        exp_q.push_back(v);
        m_cnt++;
      end
      step();
      if (i == 0) begin
        check("first_lap_data", 32'(bus.lap_data), 32'h00105);
        check("first_lap_valid", 32'(bus.lap_valid), 32'h1);
      end
      if (i == 7) begin
        check("full_after_8", 32'(bus.lap_full), 32'h1);
        check("ovf_after_8", 32'(bus.lap_ovf), 32'h0);
        check("count_after_8", 32'(bus.lap_count), 32'h8);
      end
      if (i == 8) begin
        check("ovf_after_9", 32'(bus.lap_ovf), 32'h1);
        check("count_after_9", 32'(bus.lap_count), 32'h8);
      end
    end

    // push+pop while full
    do_load(20'h00777);
    bus.lap = 1'b1;
    bus.rd_en = 1'b1;
    exp_q.push_back(20'h00777);
    step();
    check("full_pp_count", 32'(bus.lap_count), 32'h8);
    check("full_pp_ovf", 32'(bus.lap_ovf), 32'h1);
    check("full_pp_full", 32'(bus.lap_full), 32'h1);

    // drain
    for (int i = 0; i < 8; i++) begin
      bus.rd_en = 1'b1;
      step();
    end
    check("drain_valid", 32'(bus.lap_valid), 32'h0);
    check("drain_count", 32'(bus.lap_count), 32'h0);
    check("drain_full", 32'(bus.lap_full), 32'h0);
    check("drain_q_empty", 32'(exp_q.size()), 32'h0);
    bus.rd_en = 1'b1; step();
    check("empty_rd_count", 32'(bus.lap_count), 32'h0);
    check("empty_rd_valid", 32'(bus.lap_valid), 32'h0);

    // push+pop while empty
    do_load(20'h00444);
    bus.lap = 1'b1;
    bus.rd_en = 1'b1;
    exp_q.push_back(20'h00444);
    step();
    check("empty_pp_count", 32'(bus.lap_count), 32'h1);
    check("empty_pp_data", 32'(bus.lap_data), 32'h00444);
    check("empty_pp_valid", 32'(bus.lap_valid), 32'h1);
    bus.rd_en = 1'b1; step();
    check("empty_pp_drain", 32'(bus.lap_count), 32'h0);

    // tick+lap in the same cycle stores the pre-tick time
    do_load(20'h01234);
    bus.strtstop = 1'b1; step();
    bus.up = 1'b1;
    bus.tick = 1'b1;
    bus.lap = 1'b1;
    exp_q.push_back(20'h01234);
    step();
    check("tl_time", 32'(bus.time_out), 32'h01235);
    check("tl_count", 32'(bus.lap_count), 32'h1);
    check("tl_data", 32'(bus.lap_data), 32'h01234);
    bus.rd_en = 1'b1; step();
    bus.tick = 1'b1; bus.lap = 1'b1; step();
    check("pre_rst_count", 32'(bus.lap_count), 32'h1);

    // reset overrides every input while running
    reset = 1'b1;
    bus.tick = 1'b1;
    bus.lap = 1'b1;
    bus.strtstop = 1'b1;
    bus.rd_en = 1'b1;
    bus.load = 1'b1;
    step();
    check_reset_vals();
    reset = 1'b0;
    step();
    check("final_q_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/lap_timer_core.md
# lap_timer_core

Parametrised stopwatch/timer core: a BCD time counter that counts up or down from a loadable preset. It captures lap snapshots into an internal show-ahead FIFO so the display or host can drain them later. It sits between the debounced control pulses and the LCD/readout logic, running on the 100 Hz-enabled timer clock domain. Generalises the single-lap, fixed-width timer with configurable minute digits, multi-entry lap memory, countdown expiry and overflow reporting.

## Interface
- MIN_DIGITS, 1: number of BCD minute digits (1..3); time word width TW = 16 + 4*MIN_DIGITS
- LAP_DEPTH, 8: lap FIFO entries, power of two, 2..64; AW = log2(LAP_DEPTH)
- clk  in  1  single system clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle 100 Hz enable; counter advances only on tick
- strtstop  in  1  one-cycle pulse, toggles run/stop
- lap  in  1  one-cycle pulse, push current time into lap FIFO
- load  in  1  one-cycle pulse, load preset into counter
- up  in  1  1 = count up, 0 = count down; sampled every tick
- preset  in  TW  BCD preset {minutes, sec_msb, sec_lsb, tenths, hundredths}
- rd_en  in  1  pop oldest lap entry
- time_out  out  TW  current BCD time, same packing as preset
- running  out  1  high in RUN
- expired  out  1  one-cycle pulse when countdown reaches zero
- lap_data  out  TW  oldest lap entry (show-ahead)
- lap_valid  out  1  FIFO not empty
- lap_full  out  1  FIFO holds LAP_DEPTH entries
- lap_count  out  AW+1  entries held
- lap_ovf  out  1  sticky: a lap push was dropped

## Operation
- Reset: state IDLE; time_out = 0; running = 0; expired = 0; FIFO empty (lap_count = 0, lap_valid = 0, lap_full = 0); lap_data = 0; lap_ovf = 0.
- States:
  - IDLE: strtstop -> RUN; load -> time_out = preset, stay IDLE.
  - RUN: strtstop -> IDLE; countdown reaching zero -> DONE; load ignored.
  - DONE: counter holds 0; strtstop ignored; load -> time_out = preset, -> IDLE.
- Digit ranges: hundredths, tenths, sec_lsb 0-9; sec_msb 0-5; minutes 0..10^MIN_DIGITS-1 in BCD, with each minute digit 0-9. Non-BCD preset digits are loaded as-is; next count normalises each digit to 0.
- Count up (tick in RUN, up=1): ripple-carry BCD increment. At maximum (e.g. 9:59.99 for MIN_DIGITS=1) wrap to 0 and stay in RUN.
- Count down (tick in RUN, up=0): BCD decrement with borrow. Step 0:00.01 -> 0:00.00: assert expired for one cycle, enter DONE. Ticks in DONE do nothing.
- Ticking with up=0 while time_out = 0 in RUN: expired pulses, -> DONE, counter stays 0.
- Lap: push time_out as registered before that cycle's tick update, so same-cycle tick+lap stores the pre-increment value. Lap is accepted in any state.
- FIFO push while full without same-cycle pop: entry dropped, lap_ovf set. lap_ovf is cleared only by reset.
- Simultaneous push+pop when full: both happen; count unchanged.
- Simultaneous push+pop when empty: push happens, pop ignored; lap_count = 1.
- rd_en when empty: ignored, no state change.
- FIFO pointers wrap modulo LAP_DEPTH.

## Timing
- All outputs registered.
- time_out updates the cycle after tick or load, i.e. visible at the clock edge following the sampled pulse.
- running follows the state register: rises the cycle after the accepted strtstop.
- expired is high exactly one cycle, coincident with time_out first reading 0 and state DONE.
- lap_data/lap_valid: the cycle after a push into an empty FIFO, lap_data = pushed value and lap_valid = 1.
- After rd_en, lap_data shows the next entry on the following cycle.
- strtstop and load in the same cycle:
  - IDLE: load applied, then RUN.
  - RUN: load ignored, -> IDLE.
- Reset asserted mid-count or mid-FIFO activity overrides every input in that cycle.

## Test plan
- Reset, load preset 0:00.98, strtstop, 3 ticks with up=1 -> time_out 0:00.99, 0:01.00, 0:01.01; running=1.
- Up=1, time_out 9:59.99 (MIN_DIGITS=1), tick -> time_out 0:00.00, no expired, still running.
- Load 0:00.02, start, up=0, 2 ticks -> 0:00.01 then 0:00.00 with expired pulse for one cycle; 3rd tick and strtstop -> no change; load -> IDLE with preset.
- LAP_DEPTH=8: 9 laps at distinct times -> lap_full=1 after 8th, lap_ovf=1 after 9th. Then 8 rd_en -> first 8 values in order, lap_valid=0 after last.
- Full FIFO, lap+rd_en same cycle -> lap_count stays 8, lap_ovf unchanged, newest entry appears as last read.
- Tick+lap same cycle at 0:12.34 counting up -> stored 0:12.34, time_out 0:12.35; reset during RUN -> all outputs at reset values next cycle.
